// File: rtl/biquad8_coeff_seq_if.sv
// Coefficient sequencer bus: host shadow-register access plus the
// coefficient shift/update lines toward the pole-IIR DSP chain.
//   cfg_addr/cfg_data/cfg_wr : shadow write (0=A, 1=B, 2=C, 3=D)
//   cfg_commit               : request a load of the shadow set
//   busy/done                : load in progress / one-cycle completion pulse
//   coeff_dat_o/coeff_wr_o   : B1 shift data and enable
//   coeff_update_o           : B1->B2 update strobe
//   cfg_rdata                : shadow readback
// slave = sequencer side, master = host/filter side.
interface biquad8_coeff_seq_if #(
  parameter int unsigned COEFF_BITS = 18
);
  logic [1:0]            cfg_addr;
  logic [COEFF_BITS-1:0] cfg_data;
  logic                  cfg_wr;
  logic                  cfg_commit;
  logic                  busy;
  logic                  done;
  logic [COEFF_BITS-1:0] coeff_dat_o;
  logic                  coeff_wr_o;
  logic                  coeff_update_o;
  logic [COEFF_BITS-1:0] cfg_rdata;

  modport slave (
    input  cfg_addr, cfg_data, cfg_wr, cfg_commit,
    output busy, done, coeff_dat_o, coeff_wr_o, coeff_update_o, cfg_rdata
  );

  modport master (
    output cfg_addr, cfg_data, cfg_wr, cfg_commit,
    input  busy, done, coeff_dat_o, coeff_wr_o, coeff_update_o, cfg_rdata
  );
endinterface

// File: rtl/biquad8_coeff_seq.sv
// Biquad coefficient load sequencer. Four host-writable shadow registers are
// snapshotted on commit and shifted into the filter's B1 chain in the order
// C, D, B, A (so the first word lands in the last DSP), followed by
// SETTLE_CYCLES idle cycles and a single B1->B2 update strobe with done.
// Commits arriving while busy coalesce into one pending reload.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : biquad8_coeff_seq_if.slave (see interface header)
// Optional feature: define BIQUAD_COEFF_READBACK_EN to build the shadow
// readback mux on cfg_rdata; otherwise cfg_rdata is tied to 0.
module biquad8_coeff_seq #(
  parameter int unsigned COEFF_BITS    = 18,
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  biquad8_coeff_seq_if.slave   bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LOAD   = 2'd1,
    S_SETTLE = 2'd2,
    S_UPDATE = 2'd3
  } state_e;

  localparam logic [3:0] LOAD_LAST   = 4'd3;
  localparam logic [3:0] SETTLE_LAST = 4'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

  state_e                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic                  pending_q, pending_d;
  logic                  snap;
  logic [COEFF_BITS-1:0] shadow_q [4];
  logic [COEFF_BITS-1:0] shadow_d [4];
  logic [COEFF_BITS-1:0] stage_q  [4];

  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  wr_q, wr_d;
  logic                  upd_q, upd_d;
  logic [COEFF_BITS-1:0] dat_q, dat_d;

  // Shadow next value; the snapshot uses this so a same-cycle write is included.
  always_comb begin
    for (int i = 0; i < 4; i++) shadow_d[i] = shadow_q[i];
    if (bus.cfg_wr) shadow_d[bus.cfg_addr] = bus.cfg_data;
  end

  // State, counter, pending, shadow and staging registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      pending_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= '0;
        stage_q[i]  <= '0;
      end
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
      for (int i = 0; i < 4; i++) begin
        shadow_q[i] <= shadow_d[i];
        if (snap) stage_q[i] <= shadow_d[i];
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pending_d = pending_q;
    snap      = 1'b0;
    if (bus.cfg_commit && state_q != S_IDLE) pending_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.cfg_commit || pending_q) begin
          state_d   = S_LOAD;
          cnt_d     = 4'd0;
          pending_d = 1'b0;
          snap      = 1'b1;
        end
      end
      S_LOAD: begin
        if (cnt_q == LOAD_LAST) begin
          cnt_d   = 4'd0;
          state_d = (SETTLE_CYCLES == 0) ? S_UPDATE : S_SETTLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_SETTLE: begin
        if (cnt_q == SETTLE_LAST) begin
          cnt_d   = 4'd0;
          state_d = S_UPDATE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end
      S_UPDATE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode; values are registered below so outputs lag state by one cycle.
  always_comb begin
    busy_d = (state_d != S_IDLE);
    done_d = 1'b0;
    wr_d   = 1'b0;
    upd_d  = 1'b0;
    dat_d  = '0;
    case (state_q)
      S_LOAD: begin
        wr_d = 1'b1;
        case (cnt_q[1:0])
          2'd0:    dat_d = stage_q[2];
          2'd1:    dat_d = stage_q[3];
          2'd2:    dat_d = stage_q[1];
          default: dat_d = stage_q[0];
        endcase
      end
      S_UPDATE: begin
        upd_d  = 1'b1;
        done_d = 1'b1;
      end
      default: ;
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      done_q <= 1'b0;
      wr_q   <= 1'b0;
      upd_q  <= 1'b0;
      dat_q  <= '0;
    end else begin
      busy_q <= busy_d;
      done_q <= done_d;
      wr_q   <= wr_d;
      upd_q  <= upd_d;
      dat_q  <= dat_d;
    end
  end

  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.coeff_wr_o     = wr_q;
  assign bus.coeff_update_o = upd_q;
  assign bus.coeff_dat_o    = dat_q;

`ifdef BIQUAD_COEFF_READBACK_EN
  // Reads the registered shadow, so same-cycle writes appear one cycle later.
  logic [COEFF_BITS-1:0] rdata_q;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rdata_q <= '0;
    else        rdata_q <= shadow_q[bus.cfg_addr];
  end
  assign bus.cfg_rdata = rdata_q;
`else
  assign bus.cfg_rdata = '0;
`endif

endmodule

// File: doc/biquad8_coeff_seq.md
BIQUAD8_COEFF_SEQ -- requirements
Module: biquad8_coeff_seq

Interface
REQ-001 SHALL have parameter COEFF_BITS, default 18, coefficient width matching the pole-IIR B-port width.
REQ-002 SHALL have parameter SETTLE_CYCLES, default 1, number of idle cycles between the last shift write and the update strobe (0..15 legal).
REQ-003 SHALL have port clk  input  1  sole clock; one clock domain.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port cfg_addr  input  2  shadow index: 0=A, 1=B, 2=C, 3=D.
REQ-006 SHALL have port cfg_data  input  COEFF_BITS  shadow write data.
REQ-007 SHALL have port cfg_wr  input  1  write cfg_data to shadow[cfg_addr] this cycle.
REQ-008 SHALL have port cfg_commit  input  1  request to load the shadow set into the filter.
REQ-009 SHALL have port busy  output  1  high from the cycle after an accepted commit until IDLE is re-entered.
REQ-010 SHALL have port done  output  1  one-cycle pulse marking completion of a load.
REQ-011 SHALL have port coeff_dat_o  output  COEFF_BITS  to the filter coefficient data input.
REQ-012 SHALL have port coeff_wr_o  output  1  to the filter coefficient write (B1 shift) enable.
REQ-013 SHALL have port coeff_update_o  output  1  to the filter coefficient update (B1->B2) enable.
REQ-014 SHALL have port cfg_rdata  output  COEFF_BITS  shadow readback (see Configuration).

Function
REQ-015 Shadow registers SHALL accept cfg_wr in every state; a write never stalls.
REQ-016 On leaving IDLE, all four shadow values SHALL be snapshotted into staging registers; a cfg_wr in the same cycle as the accepting commit SHALL be included in the snapshot.
REQ-017 The FSM SHALL have states IDLE, LOAD, SETTLE, UPDATE; IDLE->LOAD on commit or pending; LOAD->SETTLE after 4 cycles (->UPDATE directly if SETTLE_CYCLES=0); SETTLE->UPDATE after SETTLE_CYCLES cycles; UPDATE->IDLE after 1 cycle.
REQ-018 In LOAD, coeff_wr_o SHALL be high for exactly 4 consecutive cycles with coeff_dat_o = C, D, B, A in that order, so the first written value reaches the last DSP in the chain.
REQ-019 coeff_update_o and done SHALL be high together for exactly the one UPDATE cycle; coeff_wr_o SHALL be low in that cycle.
REQ-020 All outputs SHALL be registered; with commit sampled at edge 0, coeff_wr_o is high after edges 1-4, and coeff_update_o after edge 5+SETTLE_CYCLES.
REQ-021 A commit while busy SHALL set a single pending flag (further commits coalesce); on the UPDATE->IDLE transition with pending set, the FSM SHALL re-snapshot and enter LOAD on the next cycle and clear pending.
REQ-022 coeff_dat_o SHALL be 0 whenever coeff_wr_o is low.
REQ-023 coeff_wr_o and coeff_update_o SHALL never be high in the same cycle.

Reset
REQ-024 rst_n low SHALL asynchronously force IDLE, clear shadow, staging, pending and counters, and drive busy, done, coeff_wr_o, coeff_update_o, coeff_dat_o and cfg_rdata to 0.
REQ-025 Reset mid-LOAD or mid-SETTLE SHALL suppress coeff_update_o, so the filter's active (B2) coefficients are unchanged; a partial B1 shift is overwritten by the next full load.

Configuration
REQ-026 With BIQUAD_COEFF_READBACK_EN defined, cfg_rdata SHALL return shadow[cfg_addr] one cycle after cfg_addr is presented, reflecting writes from earlier cycles.
REQ-027 Without BIQUAD_COEFF_READBACK_EN, cfg_rdata SHALL be tied to 0 and no readback mux is built.

Verification
REQ-028 Write A=0x00011, B=0x00022, C=0x00033, D=0x00044, then commit -> coeff_wr_o for 4 cycles carrying 0x33, 0x44, 0x22, 0x11; coeff_update_o and done 2 cycles later (SETTLE_CYCLES=1); busy then drops.
REQ-029 Write addr 3=0x3FFFF in the same cycle as commit -> fourth shift word unchanged, second shift word = 0x3FFFF.
REQ-030 Commit, then commit twice more and write A=0x00055 during LOAD -> exactly two loads; the second carries A=0x00055; its LOAD starts one cycle after the first done.
REQ-031 Assert rst_n=0 on the third coeff_wr_o cycle -> all outputs 0 immediately; no coeff_update_o; after release, busy=0 and shadow reads 0.
REQ-032 SETTLE_CYCLES=0 -> coeff_update_o in the cycle immediately after the fourth coeff_wr_o.
REQ-033 BIQUAD_COEFF_READBACK_EN defined: write addr 2=0x12345, set cfg_addr=2 -> cfg_rdata=0x12345 on the next cycle; undefined -> cfg_rdata stays 0.
